// File: rtl/sound_mixer.sv
// Four-channel sound mixer. On each codec sample request it snapshots the
// channel levels and NR50/NR51/NR52 routing, accumulates a zero-centred mix
// per terminal (SO1 = right, SO2 = left), scales by terminal volume and
// presents signed PCM words with a one-cycle valid strobe.
module sound_mixer #(
  parameter int OUT_WIDTH = 20,
  parameter int OUT_SHIFT = 9
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 sample_req,
  input  logic [3:0]           ch1_level,
  input  logic [3:0]           ch2_level,
  input  logic [3:0]           ch3_level,
  input  logic [3:0]           ch4_level,
  input  logic                 ch1_on_flag,
  input  logic                 ch2_on_flag,
  input  logic                 ch3_on_flag,
  input  logic                 ch4_on_flag,
  input  logic                 SO1_ch1_enable,
  input  logic                 SO1_ch2_enable,
  input  logic                 SO1_ch3_enable,
  input  logic                 SO1_ch4_enable,
  input  logic                 SO2_ch1_enable,
  input  logic                 SO2_ch2_enable,
  input  logic                 SO2_ch3_enable,
  input  logic                 SO2_ch4_enable,
  input  logic [2:0]           SO1_output_level,
  input  logic [2:0]           SO2_output_level,
  input  logic                 sound_master_enable,
  input  logic                 overrun_clr,
  output logic [OUT_WIDTH-1:0] right_sample,
  output logic [OUT_WIDTH-1:0] left_sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, ACC3, SCALE, OUT} state_t;

  state_t state_q, state_d;

  // snapshot of everything the mix depends on
  logic [3:0][3:0] lvl_q;
  logic [3:0]      on_q, so1_q, so2_q;
  logic [2:0]      vol1_q, vol2_q;
  logic            master_q;

  logic signed [7:0] acc_r_q, acc_l_q;
  logic signed [9:0] prod_r_q, prod_l_q;
  logic [OUT_WIDTH-1:0] right_q, left_q;
  logic valid_q, busy_q, overrun_q;

  // channel being accumulated and its centred contribution per terminal
  logic [1:0]        idx;
  logic              acc_en;
  logic signed [5:0] c, c_r, c_l;
  logic signed [9:0] acc_r_ext, acc_l_ext, vol1_ext, vol2_ext;
  logic [OUT_WIDTH-1:0] out_r, out_l;

  // state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: fixed walk through the four channels, scale, output
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_req) state_d = ACC0;
      ACC0:    state_d = ACC1;
      ACC1:    state_d = ACC2;
      ACC2:    state_d = ACC3;
      ACC3:    state_d = SCALE;
      SCALE:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // channel select and centred value c = 2*level - 15 (0 when channel is off)
  always_comb begin
    idx    = 2'd0;
    acc_en = 1'b1;
    case (state_q)
      ACC0:    idx = 2'd0;
      ACC1:    idx = 2'd1;
      ACC2:    idx = 2'd2;
      ACC3:    idx = 2'd3;
      default: acc_en = 1'b0;
    endcase
    c   = on_q[idx] ? ($signed({1'b0, lvl_q[idx], 1'b0}) - 6'sd15) : 6'sd0;
    c_r = so1_q[idx] ? c : 6'sd0;
    c_l = so2_q[idx] ? c : 6'sd0;
  end

  // operand widening for the volume multiply and output alignment
  always_comb begin
    acc_r_ext = {{2{acc_r_q[7]}}, acc_r_q};
    acc_l_ext = {{2{acc_l_q[7]}}, acc_l_q};
    vol1_ext  = $signed({6'd0, {1'b0, vol1_q} + 4'd1});
    vol2_ext  = $signed({6'd0, {1'b0, vol2_q} + 4'd1});
    out_r     = {{(OUT_WIDTH-10){prod_r_q[9]}}, prod_r_q} << OUT_SHIFT;
    out_l     = {{(OUT_WIDTH-10){prod_l_q[9]}}, prod_l_q} << OUT_SHIFT;
  end

  // snapshot capture, accumulate, scale and output datapath
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      lvl_q    <= '0;
      on_q     <= '0;
      so1_q    <= '0;
      so2_q    <= '0;
      vol1_q   <= '0;
      vol2_q   <= '0;
      master_q <= 1'b0;
      acc_r_q  <= '0;
      acc_l_q  <= '0;
      prod_r_q <= '0;
      prod_l_q <= '0;
      right_q  <= '0;
      left_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE && sample_req) begin
        lvl_q    <= {ch4_level, ch3_level, ch2_level, ch1_level};
        on_q     <= {ch4_on_flag, ch3_on_flag, ch2_on_flag, ch1_on_flag};
        so1_q    <= {SO1_ch4_enable, SO1_ch3_enable, SO1_ch2_enable, SO1_ch1_enable};
        so2_q    <= {SO2_ch4_enable, SO2_ch3_enable, SO2_ch2_enable, SO2_ch1_enable};
        vol1_q   <= SO1_output_level;
        vol2_q   <= SO2_output_level;
        master_q <= sound_master_enable;
        acc_r_q  <= '0;
        acc_l_q  <= '0;
      end
      if (acc_en) begin
        acc_r_q <= acc_r_q + {{2{c_r[5]}}, c_r};
        acc_l_q <= acc_l_q + {{2{c_l[5]}}, c_l};
      end
      if (state_q == SCALE) begin
        prod_r_q <= acc_r_ext * vol1_ext;
        prod_l_q <= acc_l_ext * vol2_ext;
      end
      if (state_q == OUT) begin
        right_q <= master_q ? out_r : '0;
        left_q  <= master_q ? out_l : '0;
        valid_q <= 1'b1;
      end
    end
  end

  // busy tracks the registered state; overrun is sticky, set beats clear
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (sample_req && state_q != IDLE) overrun_q <= 1'b1;
      else if (overrun_clr)              overrun_q <= 1'b0;
    end
  end

  assign right_sample = right_q;
  assign left_sample  = left_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed plus randomized checks of sound_mixer against an arithmetic model.
module tb_sound_mixer;

  logic clk = 1'b0;
  logic reset_b;
  logic sample_req;
  logic [3:0][3:0] lvl;
  logic [3:0] on, so1, so2;
  logic [2:0] vol1, vol2;
  logic master, overrun_clr;
  logic [19:0] right_sample, left_sample;
  logic sample_valid, busy, overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sound_mixer #(.OUT_WIDTH(20), .OUT_SHIFT(9)) dut (
    .clk(clk), .reset_b(reset_b), .sample_req(sample_req),
    .ch1_level(lvl[0]), .ch2_level(lvl[1]), .ch3_level(lvl[2]), .ch4_level(lvl[3]),
    .ch1_on_flag(on[0]), .ch2_on_flag(on[1]), .ch3_on_flag(on[2]), .ch4_on_flag(on[3]),
    .SO1_ch1_enable(so1[0]), .SO1_ch2_enable(so1[1]),
    .SO1_ch3_enable(so1[2]), .SO1_ch4_enable(so1[3]),
    .SO2_ch1_enable(so2[0]), .SO2_ch2_enable(so2[1]),
    .SO2_ch3_enable(so2[2]), .SO2_ch4_enable(so2[3]),
    .SO1_output_level(vol1), .SO2_output_level(vol2),
    .sound_master_enable(master), .overrun_clr(overrun_clr),
    .right_sample(right_sample), .left_sample(left_sample),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: sum of (2*level-15) over routed active channels, times (vol+1), times 2^9
  function automatic logic [19:0] ref_mix(input bit right);
    int acc = 0;
    for (int i = 0; i < 4; i++)
      if (on[i] && (right ? so1[i] : so2[i])) acc += 2 * int'(lvl[i]) - 15;
    acc = acc * ((right ? int'(vol1) : int'(vol2)) + 1) * 512;
    if (!master) acc = 0;
    return acc[19:0];
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) lvl[i] = 4'($urandom_range(0, 15));
    on     = 4'($urandom);
    so1    = 4'($urandom);
    so2    = 4'($urandom);
    vol1   = 3'($urandom);
    vol2   = 3'($urandom);
    master = 1'($urandom);
  endtask

  task automatic clear_inputs();
    lvl = '0; on = '0; so1 = '0; so2 = '0; vol1 = '0; vol2 = '0; master = 1'b1;
  endtask

  // mode 0: plain; 1: level change in ACC1 + extra request at k+2;
  // 2: extra request at k+6; 3: extra request together with overrun_clr at k+2
  task automatic run_sample(input string tag, input int mode);
    logic [19:0] exp_r, exp_l;
    int lat;
    bit seen;
    exp_r = ref_mix(1'b1);
    exp_l = ref_mix(1'b0);
    lat = 0;
    seen = 1'b0;
    @(negedge clk) sample_req = 1'b1;
    @(negedge clk) sample_req = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      if (i == 2 && mode == 1) begin lvl[0] = ~lvl[0]; sample_req = 1'b1; end
      if (i == 2 && mode == 3) begin sample_req = 1'b1; overrun_clr = 1'b1; end
      if (i == 6 && mode == 2) sample_req = 1'b1;
      if (i == 3 || i == 7) begin sample_req = 1'b0; overrun_clr = 1'b0; end
      @(negedge clk);
      if (i == 3) check({tag, ".busy"}, 32'(busy), 32'd1);
      if (sample_valid) begin seen = 1'b1; lat = i; end
    end
    sample_req = 1'b0;
    overrun_clr = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'd6);
    check({tag, ".right"}, 32'(right_sample), 32'(exp_r));
    check({tag, ".left"}, 32'(left_sample), 32'(exp_l));
    @(negedge clk);
    check({tag, ".valid_fall"}, 32'(sample_valid), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int vcount;
    reset_b = 1'b0;
    overrun_clr = 1'b0;
    sample_req = 1'b0;
    // reset with random inputs applied
    for (int n = 0; n < 4; n++) begin
      randomize_inputs();
      sample_req = 1'($urandom);
      overrun_clr = 1'($urandom);
      @(negedge clk);
    end
    check("rst.right", 32'(right_sample), 32'd0);
    check("rst.left", 32'(left_sample), 32'd0);
    check("rst.valid", 32'(sample_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    sample_req = 1'b0;
    overrun_clr = 1'b0;
    @(negedge clk) reset_b = 1'b1;

    // single channel full scale
    clear_inputs();
    lvl[0] = 4'd15; on[0] = 1'b1; so1[0] = 1'b1; so2[0] = 1'b1; vol1 = 3'd7; vol2 = 3'd7;
    run_sample("single", 0);
    check("single.right_const", 32'(right_sample), 32'h0F000);
    check("single.no_overrun", 32'(overrun), 32'd0);

    // negative full mix
    clear_inputs();
    on = 4'hF; so1 = 4'hF; so2 = 4'hF; vol1 = 3'd0; vol2 = 3'd3;
    run_sample("negmix", 0);
    check("negmix.right_const", 32'(right_sample), 32'hF8800);
    check("negmix.left_const", 32'(left_sample), 32'hE2000);

    // off flag and routing
    clear_inputs();
    lvl[0] = 4'd15; on[0] = 1'b1; so1[0] = 1'b1;
    lvl[1] = 4'd0; on[1] = 1'b0; so1[1] = 1'b1; so2[1] = 1'b1;
    vol1 = 3'd7; vol2 = 3'd7;
    run_sample("route", 0);

    // master off
    clear_inputs();
    lvl[0] = 4'd15; on[0] = 1'b1; so1[0] = 1'b1; so2[0] = 1'b1; vol1 = 3'd7; vol2 = 3'd7;
    master = 1'b0;
    run_sample("master_off", 0);

    // snapshot isolation and overrun from a request two cycles in
    clear_inputs();
    lvl[0] = 4'd12; lvl[2] = 4'd3; on = 4'b0101; so1 = 4'b0101; so2 = 4'b0001;
    vol1 = 3'd5; vol2 = 3'd2;
    run_sample("snapshot", 1);
    check("snapshot.overrun", 32'(overrun), 32'd1);

    // clear alone, then clear coinciding with a new overrun event
    @(negedge clk) overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    check("clr.alone", 32'(overrun), 32'd0);
    randomize_inputs();
    run_sample("clr_vs_set", 3);
    check("clr_vs_set.overrun", 32'(overrun), 32'd1);
    @(negedge clk) overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    check("clr.again", 32'(overrun), 32'd0);

    // request at the cycle the FSM returns to IDLE is dropped
    randomize_inputs();
    run_sample("late_req", 2);
    check("late_req.overrun", 32'(overrun), 32'd1);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sample_valid) vcount++;
    end
    check("late_req.no_valid", 32'(vcount), 32'd0);

    // reset during ACC2 aborts with no valid
    randomize_inputs();
    master = 1'b1;
    @(negedge clk) sample_req = 1'b1;
    @(negedge clk) sample_req = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_b = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.overrun", 32'(overrun), 32'd0);
    @(negedge clk) reset_b = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample_valid) vcount++;
    end
    check("abort.no_valid", 32'(vcount), 32'd0);
    check("abort.right", 32'(right_sample), 32'd0);
    check("abort.left", 32'(left_sample), 32'd0);

    // randomized mixes
    for (int n = 0; n < 20; n++) begin
      randomize_inputs();
      run_sample($sformatf("rand%0d", n), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: run did not complete, expected completion before 200000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
